// File: rtl/output_stage.sv
// Multi-channel router output stage: each channel pops its egress FIFO, registers
// the word and holds it on a req/ack handshake, with ack timeout and transfer counters.
module output_stage #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 8,
  parameter int TIMEOUT_W = 8,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [TIMEOUT_W-1:0]     timeout_cfg,
  input  logic [NUM_CH-1:0]        err_clr,
  input  logic [NUM_CH-1:0]        fifo_empty,
  output logic [NUM_CH-1:0]        fifo_pop,
  input  logic [NUM_CH*DATA_W-1:0] fifo_data,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0]        data_out_req,
  input  logic [NUM_CH-1:0]        data_out_ack,
  output logic [NUM_CH-1:0]        timeout_err,
  output logic [NUM_CH*CNT_W-1:0]  xfer_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_REQ  = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [1:0]           state;
    logic [DATA_W-1:0]    data_q;
    logic                 req_q;
    logic                 err_q;
    logic [TIMEOUT_W-1:0] wait_q;
    logic [TIMEOUT_W-1:0] wait_inc;
    logic [CNT_W-1:0]     cnt_q;
    logic                 can_pop;
    logic                 acked;
    logic                 timed_out;

    assign can_pop  = ch_en[g] & ~fifo_empty[g];
    assign acked    = (state == ST_REQ) & data_out_ack[g];
    assign wait_inc = (&wait_q) ? wait_q : wait_q + 1'b1;
    // Compared with >= so a timeout_cfg lowered mid-wait fires immediately.
    assign timed_out = (timeout_cfg != '0) && (wait_inc >= timeout_cfg);

    // The pop is combinational so the FIFO word arrives exactly in LOAD.
    assign fifo_pop[g] = rst_n & can_pop & ((state == ST_IDLE) | acked);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state  <= ST_IDLE;
        data_q <= '0;
        req_q  <= 1'b0;
        err_q  <= 1'b0;
        wait_q <= '0;
        cnt_q  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (can_pop) state <= ST_LOAD;
          end
          ST_LOAD: begin
            data_q <= fifo_data[g*DATA_W +: DATA_W];
            req_q  <= 1'b1;
            wait_q <= '0;
            state  <= ST_REQ;
          end
          ST_REQ: begin
            // Ack takes priority over a timeout landing in the same cycle.
            if (data_out_ack[g]) begin
              req_q <= 1'b0;
              if (!(&cnt_q)) cnt_q <= cnt_q + 1'b1;
              state <= can_pop ? ST_LOAD : ST_IDLE;
            end else begin
              wait_q <= wait_inc;
              if (timed_out) begin
                req_q <= 1'b0;
                err_q <= 1'b1;
                state <= ST_ERR;
              end
            end
          end
          ST_ERR: begin
            if (err_clr[g]) begin
              err_q <= 1'b0;
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end

    assign data_out[g*DATA_W +: DATA_W] = data_q;
    assign data_out_req[g]              = req_q;
    assign timeout_err[g]               = err_q;
    assign xfer_cnt[g*CNT_W +: CNT_W]   = cnt_q;
  end

endmodule

// File: tb/tb_output_stage.sv
// Self-checking bench for output_stage: FIFO model, auto-ack responder and a
// per-channel scoreboard of words expected on the output handshake.
module tb_output_stage;

  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 8;
  localparam int TIMEOUT_W = 8;
  localparam int CNT_W     = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_CH-1:0]        ch_en = '1;
  logic [TIMEOUT_W-1:0]     timeout_cfg = '0;
  logic [NUM_CH-1:0]        err_clr = '0;
  logic [NUM_CH-1:0]        fifo_empty = '1;
  logic [NUM_CH-1:0]        fifo_pop;
  logic [NUM_CH*DATA_W-1:0] fifo_data = '0;
  logic [NUM_CH*DATA_W-1:0] data_out;
  logic [NUM_CH-1:0]        data_out_req;
  logic [NUM_CH-1:0]        data_out_ack = '0;
  logic [NUM_CH-1:0]        timeout_err;
  logic [NUM_CH*CNT_W-1:0]  xfer_cnt;

  logic [DATA_W-1:0] fq    [NUM_CH][$];
  logic [DATA_W-1:0] exp_q [NUM_CH][$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [NUM_CH-1:0] auto_en = '0;
  int ack_delay [NUM_CH];
  int req_age   [NUM_CH];
  logic [DATA_W-1:0] held [NUM_CH];
  logic [NUM_CH-1:0] prev_req = '0;

  output_stage #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT_W(TIMEOUT_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .timeout_cfg(timeout_cfg),
    .err_clr(err_clr), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
    .fifo_data(fifo_data), .data_out(data_out), .data_out_req(data_out_req),
    .data_out_ack(data_out_ack), .timeout_err(timeout_err), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: read data appears the cycle after a pop; the empty flag
  // follows the queue one edge late, like a registered FIFO status.
  always @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (fifo_pop[i] && fq[i].size() > 0)
        fifo_data[i*DATA_W +: DATA_W] <= fq[i].pop_front();
      fifo_empty[i] <= (fq[i].size() == 0);
    end
  end

  // Responder: ack after ack_delay req-high cycles, held until req drops.
  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      ack_delay[i] = 0;
      req_age[i]   = 0;
      held[i]      = '0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (data_out_req[i]) req_age[i]++;
        else req_age[i] = 0;
        data_out_ack[i] = auto_en[i] && data_out_req[i] && (req_age[i] > ack_delay[i]);
      end
    end
  end

  // Scoreboard: every completed handshake must carry the next expected word,
  // and data must not move while req stays high.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_CH; i++) begin
        if (rst_n && data_out_req[i]) begin
          if (prev_req[i]) begin
            n_checks++;
            if (data_out[i*DATA_W +: DATA_W] !== held[i]) begin
              n_fail++;
              $display("[TB] FAIL stable_ch%0d: got %h want %h", i, data_out[i*DATA_W +: DATA_W], held[i]);
            end
          end
          held[i] = data_out[i*DATA_W +: DATA_W];
          if (data_out_ack[i]) begin
            n_checks++;
            if (exp_q[i].size() == 0) begin
              n_fail++;
              $display("[TB] FAIL sb_ch%0d: got %h want no transfer", i, data_out[i*DATA_W +: DATA_W]);
            end else begin
              logic [DATA_W-1:0] e;
              e = exp_q[i].pop_front();
              if (data_out[i*DATA_W +: DATA_W] !== e) begin
                n_fail++;
                $display("[TB] FAIL sb_ch%0d: got %h want %h", i, data_out[i*DATA_W +: DATA_W], e);
              end
            end
          end
        end
        prev_req[i] = data_out_req[i];
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic push_word(input int ch, input logic [DATA_W-1:0] d);
    fq[ch].push_back(d);
    exp_q[ch].push_back(d);
  endtask

  task automatic wait_pop(input int ch, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (fifo_pop[ch]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    auto_en = '0;
    ch_en = '1;
    timeout_cfg = '0;
    err_clr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      fq[i].delete();
      exp_q[i].delete();
      ack_delay[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (data_out_req !== '0 || timeout_err !== '0 || fifo_pop !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: req=%b err=%b pop=%b want all 0", data_out_req, timeout_err, fifo_pop);
    end
    n_checks++;
    if (data_out !== '0 || xfer_cnt !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: data=%h cnt=%h want 0", data_out, xfer_cnt);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    auto_en[0] = 1'b1;
    ack_delay[0] = 1;
    push_word(0, 8'hA5);
    wait_pop(0, ok);
    n_checks++;
    if (!ok || fifo_pop !== 4'b0001) begin
      n_fail++;
      $display("[TB] FAIL single_pop: got ok=%0d pop=%b want 0001", ok, fifo_pop);
    end
    @(negedge clk);
    n_checks++;
    if (data_out_req !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL single_load: req=%b want 0000", data_out_req);
    end
    @(negedge clk);
    n_checks++;
    if (data_out_req !== 4'b0001 || data_out[7:0] !== 8'hA5) begin
      n_fail++;
      $display("[TB] FAIL single_req: req=%b data=%h want 0001/a5", data_out_req, data_out[7:0]);
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (data_out_req !== 4'b0000 || xfer_cnt !== 8'h01) begin
      n_fail++;
      $display("[TB] FAIL single_done: req=%b cnt=%h want 0000/01", data_out_req, xfer_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [11:0] pops;
    logic [11:0] reqs;
    do_reset();
    auto_en[0] = 1'b1;
    ack_delay[0] = 1;
    push_word(0, 8'h11);
    push_word(0, 8'h22);
    push_word(0, 8'h33);
    wait_pop(0, ok);
    pops = '0;
    reqs = '0;
    pops[0] = fifo_pop[0];
    for (int k = 1; k < 12; k++) begin
      @(negedge clk);
      pops[k] = fifo_pop[0];
      reqs[k] = data_out_req[0];
    end
    n_checks++;
    if (!ok || pops !== 12'h049) begin
      n_fail++;
      $display("[TB] FAIL b2b_pops: got %h want 049", pops);
    end
    n_checks++;
    if (reqs !== 12'h36C) begin
      n_fail++;
      $display("[TB] FAIL b2b_reqs: got %h want 36c", reqs);
    end
    n_checks++;
    if (xfer_cnt[1:0] !== 2'd3 || exp_q[0].size() != 0) begin
      n_fail++;
      $display("[TB] FAIL b2b_cnt: got %0d left=%0d want 3/0", xfer_cnt[1:0], exp_q[0].size());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    logic [7:0] reqs;
    logic [7:0] errs;
    do_reset();
    timeout_cfg = 8'd4;
    push_word(0, 8'h5A);
    push_word(0, 8'h6B);
    wait_pop(0, ok);
    reqs = '0;
    errs = '0;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      reqs[k] = data_out_req[0];
      errs[k] = timeout_err[0];
      if (k == 5) begin
        n_checks++;
        if (data_out[7:0] !== 8'h5A) begin
          n_fail++;
          $display("[TB] FAIL to_data: got %h want 5a", data_out[7:0]);
        end
      end
    end
    n_checks++;
    if (!ok || reqs !== 8'h3C || errs !== 8'hC0) begin
      n_fail++;
      $display("[TB] FAIL to_window: req=%h err=%h want 3c/c0", reqs, errs);
    end
    void'(exp_q[0].pop_front());
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (fifo_pop[0] !== 1'b0 || timeout_err[0] !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL to_hold: pop=%b err=%b want 0/1", fifo_pop[0], timeout_err[0]);
      end
    end
    @(posedge clk);
    #1;
    err_clr[0] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (fifo_pop[0] !== 1'b0 || timeout_err[0] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL to_clr_cycle: pop=%b err=%b want 0/1", fifo_pop[0], timeout_err[0]);
    end
    @(posedge clk);
    #1;
    err_clr[0] = 1'b0;
    auto_en[0] = 1'b1;
    ack_delay[0] = 3;
    @(negedge clk);
    n_checks++;
    if (fifo_pop[0] !== 1'b1 || timeout_err[0] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL to_cleared: pop=%b err=%b want 1/0", fifo_pop[0], timeout_err[0]);
    end
    reqs = '0;
    errs = '0;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      reqs[k] = data_out_req[0];
      errs[k] = timeout_err[0];
    end
    n_checks++;
    if (reqs !== 8'h3C || errs !== 8'h00 || xfer_cnt[1:0] !== 2'd1) begin
      n_fail++;
      $display("[TB] FAIL to_ack_wins: req=%h err=%h cnt=%0d want 3c/00/1", reqs, errs, xfer_cnt[1:0]);
    end
  endtask

  task automatic test_parallel();
    bit seen;
    bit bad2;
    do_reset();
    ch_en = 4'b1011;
    ack_delay[0] = 0;
    ack_delay[1] = 1;
    ack_delay[2] = 0;
    ack_delay[3] = 2;
    auto_en = 4'b1111;
    for (int i = 0; i < NUM_CH; i++) begin
      push_word(i, 8'(i*16 + 1));
      push_word(i, 8'(i*16 + 2));
    end
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      seen = (fifo_pop != '0);
    end
    n_checks++;
    if (fifo_pop !== 4'b1011) begin
      n_fail++;
      $display("[TB] FAIL par_first_pop: got %b want 1011", fifo_pop);
    end
    bad2 = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (fifo_pop[2] || data_out_req[2]) bad2 = 1'b1;
    end
    n_checks++;
    if (bad2) begin
      n_fail++;
      $display("[TB] FAIL par_ch2_idle: got activity want none");
    end
    n_checks++;
    if (xfer_cnt !== 8'b10_00_10_10) begin
      n_fail++;
      $display("[TB] FAIL par_counts: got %b want 10001010", xfer_cnt);
    end
    @(posedge clk);
    #1;
    ch_en[2] = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (xfer_cnt[5:4] !== 2'd2 || exp_q[2].size() != 0) begin
      n_fail++;
      $display("[TB] FAIL par_ch2_resume: got %0d left=%0d want 2/0", xfer_cnt[5:4], exp_q[2].size());
    end
  endtask

  task automatic test_saturation();
    bit wrapped;
    logic [1:0] last;
    do_reset();
    auto_en[0] = 1'b1;
    ack_delay[0] = 0;
    for (int k = 0; k < 5; k++) push_word(0, 8'(8'h80 + k));
    wrapped = 1'b0;
    last = '0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (xfer_cnt[1:0] < last) wrapped = 1'b1;
      last = xfer_cnt[1:0];
    end
    n_checks++;
    if (wrapped || xfer_cnt[1:0] !== 2'd3) begin
      n_fail++;
      $display("[TB] FAIL sat_cnt: got %0d wrapped=%0d want 3/0", xfer_cnt[1:0], wrapped);
    end
    n_checks++;
    if (exp_q[0].size() != 0) begin
      n_fail++;
      $display("[TB] FAIL sat_words: got %0d left want 0", exp_q[0].size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit done;
    do_reset();
    push_word(0, 8'hC3);
    push_word(0, 8'hD4);
    wait_pop(0, ok);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (!ok || data_out_req[0] !== 1'b1 || data_out[7:0] !== 8'hC3) begin
      n_fail++;
      $display("[TB] FAIL rm_inflight: req=%b data=%h want 1/c3", data_out_req[0], data_out[7:0]);
    end
    auto_en[0] = 1'b1;
    ack_delay[0] = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fifo_pop !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL rm_pop_gate: got %b want 0000", fifo_pop);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    void'(exp_q[0].pop_front());
    @(negedge clk);
    n_checks++;
    if (data_out_req !== '0 || data_out !== '0 || xfer_cnt !== '0 || timeout_err !== '0) begin
      n_fail++;
      $display("[TB] FAIL rm_cleared: req=%b data=%h cnt=%h err=%b want 0", data_out_req, data_out, xfer_cnt, timeout_err);
    end
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      done = (xfer_cnt[1:0] == 2'd1);
    end
    n_checks++;
    if (!done || exp_q[0].size() != 0) begin
      n_fail++;
      $display("[TB] FAIL rm_resume: got cnt=%0d left=%0d want 1/0", xfer_cnt[1:0], exp_q[0].size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_parallel();
    test_saturation();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
